aes_iterative_core: RTL and testbench
=====================================

# aes_iterative_core

- Iterative, handshaked AES engine: one round per clock, encrypts or decrypts one 128-bit block.
- Key length (AES-128/192/256) is set at elaboration.
- Sits downstream of `KeyExpansion`, which supplies the flat `allKeys` bus.
- Replaces the free-running, reset-less decrypt-only core with an encrypt/decrypt block that has a valid/ready front-end and a held result with backpressure.

## Interface
- `Nk`, default 4: key length in 32-bit words (4, 6 or 8).
- `Nr`, default 10: number of rounds (10, 12 or 14); must equal `Nk + 6`.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: core can accept a request this cycle.
- `mode`  in  1: 0 = encrypt, 1 = decrypt; sampled at accept.
- `data`  in  128: input block; sampled at accept.
- `allKeys`  in  `(Nr+1)*128`: expanded key schedule.
  - Slice k is `allKeys[128*(k+1)-1 -: 128]`.
  - Slice `Nr` is the cipher key (round-0 key).
  - Must stay stable from accept until the result is taken.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `out`  out  128: result block; held while `out_valid` is high.
- `busy`  out  1: high in RUN.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- Registers:
  - `state` (128 bits).
  - `roundCount` (5 bits).
  - `modeReg` (1 bit).
- **IDLE**
  - `in_ready` is 1.
  - On `in_valid`: `state <= data ^ K0`, `modeReg <= mode`, `roundCount <= 1`, go to RUN.
  - K0 is slice `Nr` for encrypt and slice 0 for decrypt.
- **RUN**, round r = `roundCount`
  - Encrypt uses key slice `Nr-r`; decrypt uses key slice `r`.
  - For r < Nr: full round (`EncryptRound` or `DecryptRound`) into `state`, then `roundCount++`.
  - For r = Nr: last round (`LastEncryptRound` or `LastDecryptRound`) into `state`, go to DONE.
  - `in_valid` is ignored in RUN; `in_ready` is 0.
- **DONE**
  - `out_valid` is 1 and `out = state`.
  - On `out_ready` with no new request: go to IDLE.
  - `in_ready = out_ready` in DONE, so a new request can be accepted in the same cycle the result is taken. In that case the next state is RUN, with the same capture as in IDLE.
- `out` is driven directly from `state`. It changes only on accept or during RUN, never while `out_valid` is high.
- Only one round datapath (encrypt or decrypt) drives `state` per cycle, selected by `modeReg`.

## Timing
- Reset (async, `rst_n` = 0) forces:
  - FSM to IDLE.
  - `state`, `roundCount` and `modeReg` to 0.
  - `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out` = 128'h0.
- Reset mid-RUN or mid-DONE discards the block. No partial result is ever flagged valid.
- Latency: accept at edge E; `out_valid` rises after edge E+Nr.
  - That is 11 cycles for AES-128, 13 for AES-192, 15 for AES-256.
- Throughput with `out_ready` tied high: one block per Nr+1 cycles, with no idle bubble.
- Backpressure: `out_valid` and `out` are held indefinitely while `out_ready` is 0.
- `out_ready` while `out_valid` = 0 has no effect.
- `mode` and `data` changes outside the accept cycle have no effect.

## Configuration
- Macro: `AES_DECRYPT_EN`.
- Defined:
  - Decrypt round datapaths are instantiated.
  - `mode` behaves as specified above.
- Undefined:
  - Decrypt datapaths are not compiled.
  - The `mode` port remains but is ignored; `modeReg` is forced to 0.
  - Every request is encrypted with encrypt key ordering.
  - Latency and handshake are unchanged.

## Test plan
- AES-128, encrypt:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, `out_ready` = 1.
  - Response: `out` = 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` rising 11 cycles after accept.
- AES-192 and AES-256, decrypt:
  - Keys: 000102…17 and 000102…1f.
  - Data dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089 respectively.
  - Response: 00112233445566778899aabbccddeeff, with latency 13 and 15 cycles.
- Backpressure:
  - Hold `out_ready` = 0 for 20 cycles after `out_valid`.
  - Response: `out` stable, `in_ready` = 0, a pulsed `in_valid` is not accepted.
  - Then raise `out_ready` together with `in_valid` and the decrypt mode.
  - Response: new block accepted that edge, and its result equals the original plaintext.
- Back-to-back:
  - Four alternating encrypt/decrypt requests, `in_valid` and `out_ready` held high.
  - Response: results every 11 cycles, each matching the FIPS-197 vector.
- Reset at round 5 of a RUN:
  - Response: `out_valid` = 0 and `out` = 0 immediately (asynchronously), `in_ready` = 1 after release.
  - A following request produces the correct result.
- With `AES_DECRYPT_EN` undefined:
  - Stimulus: `mode` = 1 with the AES-128 vector.
  - Response: `out` = 69c4e0d86a7b0430d8cdb78070b4c55a.

Source files
------------

// File: rtl/aes_iterative_core.sv
// Purpose : iterative AES encrypt/decrypt engine, one round per clock, key length fixed by Nk/Nr.
// Latency : request accepted at edge E, result valid after edge E+Nr; one block per Nr+1 cycles.
// Backpr. : result and out_valid held while out_ready is low; in_ready only in IDLE or DONE&out_ready.
// Ports   : clk/rst_n (async active-low); in_valid/in_ready/mode/data request side;
//           allKeys expanded schedule (slice Nr = cipher key); out_valid/out_ready/out result; busy in RUN.
// Config  : define AES_DECRYPT_EN to build the decrypt datapath; otherwise mode is ignored (encrypt only).
module aes_iterative_core #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [127:0]          data,
  input  logic [(Nr+1)*128-1:0] allKeys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out,
  output logic                  busy
);

  if (Nr != Nk + 6) begin : g_bad_rounds
    $error("aes_iterative_core: Nr must equal Nk + 6");
  end

  // Byte x of the table sits at bits [8*(255-x) +: 8]; {~x,3'b0} is that offset.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [4:0] NR5 = 5'(Nr);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_e;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small GF(2^8) constant k (k <= 15), built from doublings.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  // Column-major state: byte (row, col) is at bits [127-8*(4*col+row) -: 8].
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        sr[127-8*(4*col+row) -: 8] = sub_byte(s[127-8*(4*((col+row)%4)+row) -: 8]);
    for (int col = 0; col < 4; col++) begin
      {a0, a1, a2, a3} = sr[127-32*col -: 32];
      mc[127-32*col -: 32] = {gm(a0,4'd2) ^ gm(a1,4'd3) ^ a2 ^ a3,
                              a0 ^ gm(a1,4'd2) ^ gm(a2,4'd3) ^ a3,
                              a0 ^ a1 ^ gm(a2,4'd2) ^ gm(a3,4'd3),
                              gm(a0,4'd3) ^ a1 ^ a2 ^ gm(a3,4'd2)};
    end
    return (last ? sr : mc) ^ k;
  endfunction

`ifdef AES_DECRYPT_EN
  // Inverse table derived at elaboration so it can never disagree with SBOX.
  function automatic logic [2047:0] invert_sbox(input logic [2047:0] fwd);
    logic [2047:0] inv;
    logic [7:0]    y;
    inv = '0;
    for (int i = 0; i < 256; i++) begin
      y = fwd[8*(255-i) +: 8];
      inv[8*(255-int'(y)) +: 8] = i[7:0];
    end
    return inv;
  endfunction

  localparam logic [2047:0] INV_SBOX = invert_sbox(SBOX);

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] ir, mc;
    logic [7:0]   a0, a1, a2, a3, x;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) begin
        x = s[127-8*(4*((col-row+4)%4)+row) -: 8];
        ir[127-8*(4*col+row) -: 8] = INV_SBOX[{~x, 3'b000} +: 8];
      end
    ir = ir ^ k;
    for (int col = 0; col < 4; col++) begin
      {a0, a1, a2, a3} = ir[127-32*col -: 32];
      mc[127-32*col -: 32] = {gm(a0,4'd14) ^ gm(a1,4'd11) ^ gm(a2,4'd13) ^ gm(a3,4'd9),
                              gm(a0,4'd9)  ^ gm(a1,4'd14) ^ gm(a2,4'd11) ^ gm(a3,4'd13),
                              gm(a0,4'd13) ^ gm(a1,4'd9)  ^ gm(a2,4'd14) ^ gm(a3,4'd11),
                              gm(a0,4'd11) ^ gm(a1,4'd13) ^ gm(a2,4'd9)  ^ gm(a3,4'd14)};
    end
    return last ? ir : mc;
  endfunction
`endif

  fsm_e           r_fsm, w_fsm_next;
  logic [127:0]   r_state;
  logic [4:0]     r_round_count;
  logic           r_mode_reg;
  logic           w_mode_in, w_accept, w_last;
  logic [4:0]     w_kidx;
  logic [127:0]   w_k0, w_rkey, w_enc_out, w_round_out;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_round_count == NR5);
  // Encrypt walks the schedule from slice Nr down; decrypt walks it up from slice 0.
  assign w_kidx   = r_mode_reg ? r_round_count : NR5 - r_round_count;
  assign w_rkey   = allKeys[{w_kidx, 7'd0} +: 128];
  assign w_k0     = w_mode_in ? allKeys[127:0] : allKeys[Nr*128 +: 128];
  assign w_enc_out = enc_round(r_state, w_rkey, w_last);

`ifdef AES_DECRYPT_EN
  logic [127:0] w_dec_out;
  assign w_mode_in   = mode;
  assign w_dec_out   = dec_round(r_state, w_rkey, w_last);
  assign w_round_out = r_mode_reg ? w_dec_out : w_enc_out;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_mode_in     = 1'b0;
  assign w_round_out   = w_enc_out;
`endif

  assign out = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_next;
  end

  always_comb begin
    w_fsm_next = r_fsm;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_fsm_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Taking the result frees the core in the same cycle, so no idle bubble.
        in_ready  = out_ready;
        if (out_ready) w_fsm_next = in_valid ? RUN : IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= '0;
      r_round_count <= '0;
      r_mode_reg    <= 1'b0;
    end else if (w_accept) begin
      r_state       <= data ^ w_k0;
      r_round_count <= 5'd1;
      r_mode_reg    <= w_mode_in;
    end else if (r_fsm == RUN) begin
      r_state <= w_round_out;
      if (!w_last) r_round_count <= r_round_count + 5'd1;
    end
  end

endmodule

// File: tb/tb_aes_iterative_core.sv
module tb_aes_iterative_core;
`ifdef AES_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] in_valid, mode, out_ready;
  logic [2:0][127:0]  din;
  logic [2:0][1919:0] ak;
  wire  [2:0] in_ready, out_valid, busy;
  wire  [2:0][127:0] dout;

  int total = 0;
  int bad = 0;
  logic [7:0] sbt [256];
  logic [7:0] isb [256];

  initial forever #5 clk = ~clk;

  aes_iterative_core #(.Nk(4), .Nr(10)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
    .data(din[0]), .allKeys(ak[0][1407:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out(dout[0]), .busy(busy[0]));
  aes_iterative_core #(.Nk(6), .Nr(12)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
    .data(din[1]), .allKeys(ak[1][1663:0]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out(dout[1]), .busy(busy[1]));
  aes_iterative_core #(.Nk(8), .Nr(14)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .mode(mode[2]),
    .data(din[2]), .allKeys(ak[2][1919:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out(dout[2]), .busy(busy[2]));

  // ---------------- reference model (FIPS-197 from first principles) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox;
    logic [7:0] v, b, s;
    for (int x = 0; x < 256; x++) begin
      v = x[7:0];
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(v, y[7:0]) == 8'h01) b = y[7:0];
      s = b ^ rol(b, 1) ^ rol(b, 2) ^ rol(b, 3) ^ rol(b, 4) ^ 8'h63;
      sbt[x] = s;
      isb[s] = v;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  // Flat schedule: slice (nr-k) carries round key k, so slice nr is the cipher key.
  task automatic expand(input logic [255:0] key, input int nk, output logic [1919:0] akv);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr = nk + 6; rcon = 8'h01; akv = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k <= nr; k++) akv[128*(nr-k) +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [7:0] coef(input bit inv, input int i);
    case (i)
      0: return inv ? 8'h0e : 8'h02;
      1: return inv ? 8'h0b : 8'h03;
      2: return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] x, input logic [1919:0] akv, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] acc;
    logic [127:0] k, res;
    k = akv[128*nr +: 128];
    for (int i = 0; i < 16; i++) s[i] = x[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) t[r+4*c] = sbt[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef(1'b0, (j-r+4)%4), t[j+4*c]);
        s[r+4*c] = (rnd < nr) ? acc : t[r+4*c];
      end
      k = akv[128*(nr-rnd) +: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] x, input logic [1919:0] akv, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] acc;
    logic [127:0] k, res;
    k = akv[127:0];
    for (int i = 0; i < 16; i++) s[i] = x[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      k = akv[128*rnd +: 128];
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++)
        t[r+4*c] = isb[s[r+4*((c-r+4)%4)]] ^ k[127-8*(r+4*c) -: 8];
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef(1'b1, (j-r+4)%4), t[j+4*c]);
        s[r+4*c] = (rnd < nr) ? acc : t[r+4*c];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Without the decrypt build every request is an encryption.
  function automatic logic [127:0] model(input bit m, input logic [127:0] x, input logic [1919:0] akv, input int nr);
    return (m && DEC_EN) ? model_dec(x, akv, nr) : model_enc(x, akv, nr);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Call at a negedge with the DUT ready; returns 1 time unit after the accept edge.
  task automatic issue(input int d, input bit m, input logic [127:0] x);
    in_valid[d] = 1'b1; mode[d] = m; din[d] = x;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0; mode[d] = 1'($urandom); din[d] = rnd128();
  endtask

  // Counts negedges after the accept edge until out_valid (Nr+1 expected); bounded.
  task automatic wait_valid(input int d, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid[d] && cyc < 60);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++; if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_in_ready d=%0d got=%b want=1", d, in_ready[d]); end
      total++; if (out_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid d=%0d got=%b want=0", d, out_valid[d]); end
      total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy d=%0d got=%b want=0", d, busy[d]); end
      total++; if (dout[d] !== 128'h0) begin bad++; $display("FAIL reset_out d=%0d got=%h want=0", d, dout[d]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_encrypt_128;
    int cyc;
    @(negedge clk);
    issue(0, 1'b0, PT);
    total++; if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin bad++; $display("FAIL enc128_busy got busy=%b in_ready=%b want 1/0", busy[0], in_ready[0]); end
    wait_valid(0, cyc);
    total++; if (cyc != 11) begin bad++; $display("FAIL enc128_latency got=%0d want=11", cyc); end
    total++; if (dout[0] !== CT128) begin bad++; $display("FAIL enc128_out got=%h want=%h", dout[0], CT128); end
    @(negedge clk);
    total++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin bad++; $display("FAIL enc128_taken got out_valid=%b in_ready=%b want 0/1", out_valid[0], in_ready[0]); end
  endtask

  task automatic test_decrypt_192_256;
    int cyc;
    logic [127:0] ct, exp;
    for (int d = 1; d < 3; d++) begin
      ct  = (d == 1) ? CT192 : CT256;
      exp = DEC_EN ? PT : model_enc(ct, ak[d], 10 + 2*d);
      @(negedge clk);
      issue(d, 1'b1, ct);
      wait_valid(d, cyc);
      total++; if (cyc != 11 + 2*d) begin bad++; $display("FAIL dec_latency d=%0d got=%0d want=%0d", d, cyc, 11 + 2*d); end
      total++; if (dout[d] !== exp) begin bad++; $display("FAIL dec_out d=%0d got=%h want=%h", d, dout[d], exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_mode_ignored_or_decrypt;
    int cyc;
    logic [127:0] exp;
    exp = DEC_EN ? model_dec(PT, ak[0], 10) : CT128;
    @(negedge clk);
    issue(0, 1'b1, PT);
    wait_valid(0, cyc);
    total++; if (dout[0] !== exp || cyc != 11) begin bad++; $display("FAIL mode1_128 got=%h lat=%0d want=%h lat=11", dout[0], cyc, exp); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [127:0] held, exp;
    out_ready[0] = 1'b0;
    @(negedge clk);
    issue(0, 1'b0, PT);
    wait_valid(0, cyc);
    held = dout[0];
    total++; if (held !== CT128) begin bad++; $display("FAIL bp_first got=%h want=%h", held, CT128); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (out_valid[0] !== 1'b1 || dout[0] !== CT128 || in_ready[0] !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b out=%h want 1/0/%h", i, out_valid[0], in_ready[0], dout[0], CT128);
      end
      in_valid[0] = (i == 5);
      din[0] = rnd128();
    end
    in_valid[0] = 1'b1; out_ready[0] = 1'b1; mode[0] = 1'b1; din[0] = CT128;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    total++; if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin bad++; $display("FAIL bp_accept got busy=%b out_valid=%b want 1/0", busy[0], out_valid[0]); end
    exp = DEC_EN ? PT : model_enc(CT128, ak[0], 10);
    wait_valid(0, cyc);
    total++; if (cyc != 11 || dout[0] !== exp) begin bad++; $display("FAIL bp_result got=%h lat=%0d want=%h lat=11", dout[0], cyc, exp); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [127:0] exp;
    @(negedge clk);
    in_valid[0] = 1'b1; mode[0] = 1'b0; din[0] = PT;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1) ? (DEC_EN ? PT : model_enc(CT128, ak[0], 10)) : CT128;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          if (i < 3) begin mode[0] = ((i + 1) % 2 == 1); din[0] = mode[0] ? CT128 : PT; end
          else in_valid[0] = 1'b0;
        end
      end while (!out_valid[0] && cyc < 60);
      total++; if (cyc != 11) begin bad++; $display("FAIL b2b_spacing i=%0d got=%0d want=11", i, cyc); end
      total++; if (dout[0] !== exp) begin bad++; $display("FAIL b2b_out i=%0d got=%h want=%h", i, dout[0], exp); end
      @(posedge clk);
    end
    @(negedge clk);
    total++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin bad++; $display("FAIL b2b_idle got v=%b rdy=%b want 0/1", out_valid[0], in_ready[0]); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    logic [127:0] x;
    @(negedge clk);
    issue(0, 1'b0, rnd128());
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (out_valid[0] !== 1'b0 || dout[0] !== 128'h0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL midrst_async got v=%b busy=%b out=%h want 0/0/0", out_valid[0], busy[0], dout[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready[0]); end
    x = rnd128();
    @(negedge clk);
    issue(0, 1'b0, x);
    wait_valid(0, cyc);
    total++; if (cyc != 11 || dout[0] !== model_enc(x, ak[0], 10)) begin
      bad++; $display("FAIL midrst_next got=%h lat=%0d want=%h lat=11", dout[0], cyc, model_enc(x, ak[0], 10));
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int cyc, stall;
    bit m;
    logic [127:0] x, exp, held;
    logic [1919:0] kv;
    for (int it = 0; it < 6; it++) begin
      for (int d = 0; d < 3; d++) begin
        expand({rnd128(), rnd128()}, 4 + 2*d, kv);
        ak[d] = kv;
        x = rnd128();
        m = 1'($urandom_range(0, 1));
        exp = model(m, x, kv, 10 + 2*d);
        stall = $urandom_range(0, 3);
        out_ready[d] = (stall == 0);
        @(negedge clk);
        issue(d, m, x);
        wait_valid(d, cyc);
        held = dout[d];
        total++; if (cyc != 11 + 2*d || held !== exp) begin
          bad++; $display("FAIL rand d=%0d it=%0d m=%0d got=%h lat=%0d want=%h lat=%0d", d, it, m, held, cyc, exp, 11 + 2*d);
        end
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          total++; if (out_valid[d] !== 1'b1 || dout[d] !== exp) begin bad++; $display("FAIL rand_hold d=%0d got=%h want=%h", d, dout[d], exp); end
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        total++; if (out_valid[d] !== 1'b0) begin bad++; $display("FAIL rand_drain d=%0d got=%b want=0", d, out_valid[d]); end
      end
    end
  endtask

  initial begin
    logic [1919:0] kv;
    in_valid = '0; mode = '0; out_ready = '1; din = '0; ak = '0;
    build_sbox();
    for (int d = 0; d < 3; d++) begin
      expand(FIPS_KEY, 4 + 2*d, kv);
      ak[d] = kv;
    end
    test_reset();
    test_encrypt_128();
    test_decrypt_192_256();
    test_mode_ignored_or_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
